// File: rtl/ws2812_stream_decoder.sv
// WS2812 one-wire stream decoder: pulse-width bit decode, 24-bit pixel strobes, latch detection.
// Define WS2812_DECODER_SYNC_EN to put a 2-flop synchronizer in front of the decoder.
module ws2812_stream_decoder #(
  parameter int unsigned THRESHOLD_CYCLES = 7,
  parameter int unsigned MIN_HIGH_CYCLES  = 2,
  parameter int unsigned MAX_HIGH_CYCLES  = 13,
  parameter int unsigned LATCH_CYCLES     = 600,
  parameter int unsigned LED_COUNT        = 22
) (
  input  logic        clock_12mhz,
  input  logic        reset_n,
  input  logic        data_in,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  led_index,
  output logic        frame_done,
  output logic        error
);

  localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [3:0]    THR_H      = 4'(THRESHOLD_CYCLES);
  localparam logic [3:0]    MIN_H      = 4'(MIN_HIGH_CYCLES);
  localparam logic [3:0]    MAX_H      = 4'(MAX_HIGH_CYCLES);
  localparam logic [3:0]    HIGH_SAT   = 4'(MAX_HIGH_CYCLES + 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [LW-1:0] LOW_SAT    = LW'(LATCH_CYCLES);
  localparam logic [7:0]    LED_MAX    = 8'(LED_COUNT);

  typedef enum logic [1:0] {WAIT_LATCH, IDLE_LOW, HIGH, LOW} state_t;

  state_t        state, next_state;
  logic          din_s;
  logic [3:0]    high_cnt;
  logic [LW-1:0] low_cnt;
  logic [4:0]    bit_cnt;
  logic [22:0]   shift;
  logic [7:0]    pix_cnt;
  logic          bit_done, bad_pulse, latch_evt, bit_val;
  logic [23:0]   shift_next;

`ifdef WS2812_DECODER_SYNC_EN
  logic sync1;
  always_ff @(posedge clock_12mhz) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      din_s <= 1'b0;
    end else begin
      sync1 <= data_in;
      din_s <= sync1;
    end
  end
`else
  always_ff @(posedge clock_12mhz) begin
    if (!reset_n) din_s <= 1'b0;
    else          din_s <= data_in;
  end
`endif

  always_ff @(posedge clock_12mhz) begin
    if (!reset_n) state <= WAIT_LATCH;
    else          state <= next_state;
  end

  // Edges are implied by the state: din_s=0 while in HIGH is the falling edge, and so on.
  always_comb begin
    next_state = state;
    bit_done   = 1'b0;
    bad_pulse  = 1'b0;
    latch_evt  = 1'b0;
    case (state)
      WAIT_LATCH: if (!din_s && low_cnt >= LATCH_LAST) next_state = IDLE_LOW;
      IDLE_LOW:   if (din_s) next_state = HIGH;
      HIGH: begin
        if (!din_s) begin
          if (high_cnt < MIN_H || high_cnt > MAX_H) begin
            bad_pulse  = 1'b1;
            next_state = WAIT_LATCH;
          end else begin
            bit_done   = 1'b1;
            next_state = LOW;
          end
        end
      end
      LOW: begin
        if (din_s) next_state = HIGH;
        else if (low_cnt >= LATCH_LAST) begin
          latch_evt  = 1'b1;
          next_state = IDLE_LOW;
        end
      end
      default: next_state = WAIT_LATCH;
    endcase
  end

  assign bit_val    = (high_cnt >= THR_H);
  assign shift_next = {shift, bit_val};

  always_ff @(posedge clock_12mhz) begin
    if (!reset_n) begin
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      pix_cnt     <= '0;
      pixel_data  <= '0;
      led_index   <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      case (state)
        WAIT_LATCH: low_cnt <= din_s ? '0 : low_cnt + 1'b1;
        IDLE_LOW:   if (din_s) high_cnt <= 4'd1;
        HIGH: begin
          if (din_s) begin
            if (high_cnt != HIGH_SAT) high_cnt <= high_cnt + 4'd1;
          end else if (bad_pulse) begin
            // Aborted frame is dropped entirely so the next clean frame starts at index 0.
            error   <= 1'b1;
            bit_cnt <= '0;
            shift   <= '0;
            pix_cnt <= '0;
            low_cnt <= {{(LW-1){1'b0}}, 1'b1};
          end else if (bit_done) begin
            low_cnt <= {{(LW-1){1'b0}}, 1'b1};
            shift   <= shift_next[22:0];
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_cnt < LED_MAX) begin
                pixel_data  <= shift_next;
                led_index   <= pix_cnt;
                pixel_valid <= 1'b1;
                pix_cnt     <= pix_cnt + 8'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        LOW: begin
          if (din_s) begin
            high_cnt <= 4'd1;
          end else if (latch_evt) begin
            frame_done <= (pix_cnt != '0);
            error      <= (bit_cnt != '0);
            pix_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
          end else if (low_cnt != LOW_SAT) begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
